sdfp_integrator_chain: RTL and testbench

//  Parametrised cascade of ORDER signed integrators forming the loop filter of the SDFP

---
 rtl/sdfp_integrator_chain_if.sv | 25 ++
 rtl/sdfp_integrator_chain.sv | 71 +++++++
 tb/tb_sdfp_integrator_chain.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sdfp_integrator_chain_if.sv
// rtl/sdfp_integrator_chain_if.sv - sample/feedback bus of the SDFP loop-filter integrator chain
// The driver side is the master; the integrator chain is the slave.
interface sdfp_integrator_chain_if #(
  parameter int BW    = 24,
  parameter int ORDER = 4
);
  logic              in_valid;
  logic [BW-1:0]     in_data;
  logic [BW-1:0]     fb;
  logic              clear;
  logic              ovf_clr;
  logic              out_valid;
  logic [BW-1:0]     out_data;
  logic [ORDER-1:0]  ovf;

  modport master (
    output in_valid, in_data, fb, clear, ovf_clr,
    input  out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, fb, clear, ovf_clr,
    output out_valid, out_data, ovf
  );
endinterface

// File: rtl/sdfp_integrator_chain.sv
// rtl/sdfp_integrator_chain.sv - cascade of ORDER signed integrators with saturate/wrap and sticky overflow
// Every stage adds its predecessor's registered value and subtracts the shared quantiser feedback.
module sdfp_integrator_chain #(
  parameter int BW    = 24,
  parameter int ORDER = 4,
  parameter int SAT   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sdfp_integrator_chain_if.slave bus
);

  localparam int EW = BW + 2;
  localparam logic signed [EW-1:0] MAX_V = {3'b000, {(BW-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {3'b111, {(BW-1){1'b0}}};

  logic [BW-1:0]          acc_q  [ORDER];
  logic [BW-1:0]          acc_d  [ORDER];
  logic [BW-1:0]          prev_w [ORDER];
  logic signed [EW-1:0]   sum_w  [ORDER];
  logic [ORDER-1:0]       hit_w;
  logic [ORDER-1:0]       ovf_q;
  logic                   out_valid_q;
  logic                   upd_w;

  function automatic logic signed [EW-1:0] sext(input logic [BW-1:0] x);
    return {{2{x[BW-1]}}, x};
  endfunction

  assign upd_w = bus.in_valid & ~bus.clear;

  always_comb begin
    hit_w = '0;
    prev_w[0] = bus.in_data;
    for (int k = 1; k < ORDER; k++) prev_w[k] = acc_q[k-1];
    for (int k = 0; k < ORDER; k++) begin
      // BW+2 bits hold the sum of three BW-bit operands exactly
      sum_w[k] = sext(acc_q[k]) + sext(prev_w[k]) - sext(bus.fb);
      hit_w[k] = (sum_w[k] > MAX_V) || (sum_w[k] < MIN_V);
      if ((SAT != 0) && (sum_w[k] > MAX_V)) begin
        acc_d[k] = MAX_V[BW-1:0];
      end else if ((SAT != 0) && (sum_w[k] < MIN_V)) begin
        acc_d[k] = MIN_V[BW-1:0];
      end else begin
        acc_d[k] = sum_w[k][BW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= upd_w;
      if (bus.clear) begin
        for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
      end else if (bus.in_valid) begin
        for (int k = 0; k < ORDER; k++) acc_q[k] <= acc_d[k];
      end
      // a fresh overflow in the clearing cycle wins over ovf_clr
      ovf_q <= (bus.ovf_clr ? '0 : ovf_q) | (upd_w ? hit_w : '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q[ORDER-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sdfp_integrator_chain.sv
// tb/tb_sdfp_integrator_chain.sv - directed bench for sdfp_integrator_chain, saturating and wrapping copies
// Both copies see identical stimulus; BW=8, ORDER=2.
module tb_sdfp_integrator_chain;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sdfp_integrator_chain_if #(.BW(8), .ORDER(2)) if_s ();
  sdfp_integrator_chain_if #(.BW(8), .ORDER(2)) if_w ();

  assign if_w.in_valid = if_s.in_valid;
  assign if_w.in_data  = if_s.in_data;
  assign if_w.fb       = if_s.fb;
  assign if_w.clear    = if_s.clear;
  assign if_w.ovf_clr  = if_s.ovf_clr;

  sdfp_integrator_chain #(.BW(8), .ORDER(2), .SAT(1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_s.slave)
  );
  sdfp_integrator_chain #(.BW(8), .ORDER(2), .SAT(0)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_w.slave)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic cyc(input logic v, input int d, input int f, input logic c, input logic oc);
    if_s.in_valid = v;
    if_s.in_data  = 8'(d);
    if_s.fb       = 8'(f);
    if_s.clear    = c;
    if_s.ovf_clr  = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.fb = '0;
    if_s.clear = 1'b0; if_s.ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_s.out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", if_s.out_data); end
    checks++; if (if_s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", if_s.out_valid); end
    checks++; if (if_s.ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b exp 00", if_s.ovf); end
    checks++; if (dut_s.acc_q[0] !== 8'd0) begin errors++; $display("FAIL reset_acc0 got %0d exp 0", dut_s.acc_q[0]); end
    #3 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse;
    int exp_out[4] = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0) ? 1 : 0, 0, 1'b0, 1'b0);
      checks++; if ($signed(dut_s.acc_q[0]) !== 1) begin errors++; $display("FAIL impulse_acc0[%0d] got %0d exp 1", i, $signed(dut_s.acc_q[0])); end
      checks++; if ($signed(if_s.out_data) !== exp_out[i]) begin errors++; $display("FAIL impulse_out[%0d] got %0d exp %0d", i, $signed(if_s.out_data), exp_out[i]); end
      checks++; if (if_s.out_valid !== 1'b1) begin errors++; $display("FAIL impulse_valid[%0d] got %b exp 1", i, if_s.out_valid); end
    end
    cyc(1'b0, 7, 0, 1'b0, 1'b0);
    checks++; if (if_s.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", if_s.out_valid); end
    checks++; if ($signed(if_s.out_data) !== 3) begin errors++; $display("FAIL idle_hold got %0d exp 3", $signed(if_s.out_data)); end
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    checks++; if (if_s.out_data !== 8'd0) begin errors++; $display("FAIL clear_out got %0d exp 0", if_s.out_data); end
  endtask

  task automatic test_overflow;
    cyc(1'b1, 100, 0, 1'b0, 1'b0);
    checks++; if ($signed(dut_s.acc_q[0]) !== 100) begin errors++; $display("FAIL sat_acc0_1 got %0d exp 100", $signed(dut_s.acc_q[0])); end
    checks++; if (if_s.ovf !== 2'b00) begin errors++; $display("FAIL sat_ovf_1 got %b exp 00", if_s.ovf); end
    cyc(1'b1, 100, 0, 1'b0, 1'b0);
    checks++; if ($signed(dut_s.acc_q[0]) !== 127) begin errors++; $display("FAIL sat_acc0_2 got %0d exp 127", $signed(dut_s.acc_q[0])); end
    checks++; if (if_s.ovf !== 2'b01) begin errors++; $display("FAIL sat_ovf_2 got %b exp 01", if_s.ovf); end
    checks++; if ($signed(if_s.out_data) !== 100) begin errors++; $display("FAIL sat_out_2 got %0d exp 100", $signed(if_s.out_data)); end
    checks++; if ($signed(dut_w.acc_q[0]) !== -56) begin errors++; $display("FAIL wrap_acc0_2 got %0d exp -56", $signed(dut_w.acc_q[0])); end
    checks++; if (if_w.ovf !== 2'b01) begin errors++; $display("FAIL wrap_ovf_2 got %b exp 01", if_w.ovf); end
    cyc(1'b1, 0, 0, 1'b0, 1'b0);
    checks++; if ($signed(if_s.out_data) !== 127) begin errors++; $display("FAIL sat_out_3 got %0d exp 127", $signed(if_s.out_data)); end
    checks++; if (if_s.ovf !== 2'b11) begin errors++; $display("FAIL sat_ovf_3 got %b exp 11", if_s.ovf); end
    checks++; if ($signed(if_w.out_data) !== 44) begin errors++; $display("FAIL wrap_out_3 got %0d exp 44", $signed(if_w.out_data)); end
    checks++; if (if_w.ovf !== 2'b01) begin errors++; $display("FAIL wrap_ovf_3 got %b exp 01", if_w.ovf); end
  endtask

  task automatic test_priority;
    cyc(1'b1, 5, 0, 1'b1, 1'b0);
    checks++; if (dut_s.acc_q[0] !== 8'd0 || if_s.out_data !== 8'd0) begin errors++; $display("FAIL prio_acc got %0d/%0d exp 0/0", dut_s.acc_q[0], if_s.out_data); end
    checks++; if (if_s.out_valid !== 1'b0) begin errors++; $display("FAIL prio_valid got %b exp 0", if_s.out_valid); end
    checks++; if (if_s.ovf !== 2'b11) begin errors++; $display("FAIL prio_ovf_s got %b exp 11", if_s.ovf); end
    checks++; if (if_w.ovf !== 2'b01) begin errors++; $display("FAIL prio_ovf_w got %b exp 01", if_w.ovf); end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    checks++; if (if_s.ovf !== 2'b00) begin errors++; $display("FAIL ovf_clr got %b exp 00", if_s.ovf); end
    cyc(1'b1, 100, 0, 1'b0, 1'b0);
    cyc(1'b1, 100, 0, 1'b0, 1'b1);
    checks++; if (if_s.ovf !== 2'b01) begin errors++; $display("FAIL ovf_set_wins got %b exp 01", if_s.ovf); end
    cyc(1'b0, 0, 0, 1'b1, 1'b1);
    checks++; if (if_s.ovf !== 2'b00) begin errors++; $display("FAIL ovf_clr_2 got %b exp 00", if_s.ovf); end
  endtask

  task automatic test_feedback;
    cyc(1'b1, 0, 10, 1'b0, 1'b0);
    checks++; if ($signed(dut_s.acc_q[0]) !== -10) begin errors++; $display("FAIL fb_acc0_1 got %0d exp -10", $signed(dut_s.acc_q[0])); end
    checks++; if ($signed(if_s.out_data) !== -10) begin errors++; $display("FAIL fb_out_1 got %0d exp -10", $signed(if_s.out_data)); end
    cyc(1'b1, 0, 10, 1'b0, 1'b0);
    checks++; if ($signed(dut_s.acc_q[0]) !== -20) begin errors++; $display("FAIL fb_acc0_2 got %0d exp -20", $signed(dut_s.acc_q[0])); end
    checks++; if ($signed(if_s.out_data) !== -30) begin errors++; $display("FAIL fb_out_2 got %0d exp -30", $signed(if_s.out_data)); end
    checks++; if (if_s.ovf !== 2'b00) begin errors++; $display("FAIL fb_ovf got %b exp 00", if_s.ovf); end
  endtask

  task automatic test_midstream_reset;
    cyc(1'b1, 40, 0, 1'b0, 1'b0);
    cyc(1'b1, 100, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_s.out_data !== 8'd0 || dut_s.acc_q[0] !== 8'd0) begin errors++; $display("FAIL mid_rst_acc got %0d/%0d exp 0/0", if_s.out_data, dut_s.acc_q[0]); end
    checks++; if (if_s.ovf !== 2'b00 || if_s.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b/%b exp 00/0", if_s.ovf, if_s.out_valid); end
    rst_n = 1'b1;
    cyc(1'b1, 3, 0, 1'b0, 1'b0);
    checks++; if ($signed(dut_s.acc_q[0]) !== 3 || if_s.out_data !== 8'd0) begin errors++; $display("FAIL post_rst_1 got %0d/%0d exp 3/0", $signed(dut_s.acc_q[0]), if_s.out_data); end
    cyc(1'b1, 0, 0, 1'b0, 1'b0);
    checks++; if ($signed(if_s.out_data) !== 3) begin errors++; $display("FAIL post_rst_2 got %0d exp 3", $signed(if_s.out_data)); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_overflow();
    test_priority();
    test_feedback();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
